ddr3_burst_reader: RTL and testbench

Read-back checker for the DDR3 burst test path. On a start pulse it issues one read burst on the DDRAM interface, captures each returned beat and compares it against the incrementing pattern the burst writer stores (beat index in bits [7:0], zeros in bits [31:8]). It reports pass/fail, an error count and the first failing beat. Sits beside the writer on the DDRAM clock domain and drives the status shown by the core.

---
 rtl/ddr3_burst_reader.sv | 164 ++++++++++++++++
 tb/tb_ddr3_burst_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_reader.sv
// DDR3 read-back checker: issues one read burst and compares each beat against the writer's index pattern.
// Optional beat watchdog compiled in with `define DDR3_READ_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for start, results held
// REQ   | ddram_rd asserted until the controller accepts
// DATA  | counting and checking returned beats
// DONE  | one-cycle completion pulse, result final
module ddr3_burst_reader #(
  parameter int          BURST_LEN = 128,
  parameter logic [28:0] BASE_ADDR = 29'h2400000,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic        ddram_rd,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  first_err_idx,
  output logic [31:0] first_err_data,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  fidx_q, fidx_d;
  logic [31:0] fdata_q, fdata_d;
  logic        pass_q, pass_d;
  logic        beat_mis;

  // Upper half of the beat is never written by the burst writer.
  logic unused_dout_hi;
  assign unused_dout_hi = ^ddram_dout[63:32];

`ifdef DDR3_READ_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
  assign timeout = tmo_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

  assign ddram_burstcnt = 8'(BURST_LEN);
  assign ddram_addr     = BASE_ADDR;
  assign ddram_rd       = (state_q == REQ);
  assign busy           = (state_q == REQ) || (state_q == DATA);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;

  assign beat_mis = (ddram_dout[31:0] != {24'h0, beat_q});

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
    pass_d  = pass_q;
`ifdef DDR3_READ_WATCHDOG_EN
    wd_d    = wd_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          beat_d  = 8'h00;
          err_d   = 8'h00;
          fidx_d  = 8'h00;
          fdata_d = 32'h0;
          pass_d  = 1'b0;
`ifdef DDR3_READ_WATCHDOG_EN
          tmo_d   = 1'b0;
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        if (!ddram_busy) begin
`ifdef DDR3_READ_WATCHDOG_EN
          wd_d = WD_RELOAD;
`endif
          state_d = DATA;
        end
      end
      DATA: begin
        if (ddram_dout_ready) begin
          beat_d = beat_q + 8'd1;
`ifdef DDR3_READ_WATCHDOG_EN
          wd_d   = WD_RELOAD;
`endif
          if (beat_mis) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'h00) begin
              fidx_d  = beat_q;
              fdata_d = ddram_dout[31:0];
            end
          end
          if (beat_q == LAST_IDX) begin
            // err_d already includes the final beat's result.
            pass_d  = (err_d == 8'h00);
            state_d = DONE;
          end
        end
`ifdef DDR3_READ_WATCHDOG_EN
        else if (wd_q == '0) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= 8'h00;
      err_q   <= 8'h00;
      fidx_q  <= 8'h00;
      fdata_q <= 32'h0;
      pass_q  <= 1'b0;
`ifdef DDR3_READ_WATCHDOG_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      pass_q  <= pass_d;
`ifdef DDR3_READ_WATCHDOG_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Directed bench for ddr3_burst_reader; a memory model returns the writer's index pattern per beat.
// Build with DDR3_READ_WATCHDOG_EN to exercise the watchdog with TIMEOUT=16.
module tb_ddr3_burst_reader;

  localparam int BL = 128;
`ifdef DDR3_READ_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ddram_busy = 1'b0;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic        ddram_rd;
  logic [63:0] ddram_dout = 64'h0;
  logic        ddram_dout_ready = 1'b0;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count, first_err_idx;
  logic [31:0] first_err_data;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rd_rise = 0;
  logic rd_prev = 1'b0;

  ddr3_burst_reader #(.BURST_LEN(BL), .BASE_ADDR(29'h2400000), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .ddram_busy(ddram_busy),
    .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr), .ddram_rd(ddram_rd),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ddram_rd === 1'b1 && rd_prev !== 1'b1) rd_rise++;
    rd_prev = ddram_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present beats first..last; optional random gaps, two corrupted indices, start pulse on one beat.
  task automatic deliver(input int first, input int last, input int max_gap,
                         input int bad_a, input int bad_b, input int start_at);
    for (int i = first; i <= last; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        repeat (g) begin
          ddram_dout_ready = 1'b0;
          ddram_dout = {$urandom, $urandom};
          tick();
        end
      end
      ddram_dout_ready = 1'b1;
      ddram_dout[63:32] = $urandom;
      ddram_dout[31:0] = (i == bad_a || i == bad_b) ? 32'hFF : 32'(i);
      start = (i == start_at);
      tick();
    end
    ddram_dout_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic start_accept();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_vec++; if (ddram_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b expected 0", ddram_rd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %b expected 0", pass); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL rst_err: got %0h expected 0", err_count); end
    n_vec++; if (first_err_idx !== 8'h00) begin n_err++; $display("FAIL rst_fidx: got %0h expected 0", first_err_idx); end
    n_vec++; if (first_err_data !== 32'h0) begin n_err++; $display("FAIL rst_fdata: got %0h expected 0", first_err_data); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    n_vec++; if (ddram_burstcnt !== 8'h80) begin n_err++; $display("FAIL burstcnt: got %0h expected 80", ddram_burstcnt); end
    n_vec++; if (ddram_addr !== 29'h2400000) begin n_err++; $display("FAIL addr: got %0h expected 2400000", ddram_addr); end
  endtask

  task automatic test_clean();
    int d0, r0;
    d0 = done_cnt; r0 = rd_rise;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (ddram_rd !== 1'b1) begin n_err++; $display("FAIL clean_rd_rise: got %b expected 1", ddram_rd); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy: got %b expected 1", busy); end
    tick();
    n_vec++; if (ddram_rd !== 1'b0) begin n_err++; $display("FAIL clean_rd_fall: got %b expected 0", ddram_rd); end
    deliver(0, BL - 1, 0, -1, -1, -1);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL clean_done: got %b expected 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_end: got %b expected 0", busy); end
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL clean_pass: got %b expected 1", pass); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL clean_err: got %0h expected 0", err_count); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL clean_done_clr: got %b expected 0", done); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL clean_done_cnt: got %0d expected 1", done_cnt - d0); end
    n_vec++; if (rd_rise - r0 !== 1) begin n_err++; $display("FAIL clean_req_cnt: got %0d expected 1", rd_rise - r0); end
  endtask

  task automatic test_backpressure();
    int d0, r0;
    d0 = done_cnt; r0 = rd_rise;
    ddram_busy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (ddram_rd !== 1'b1 || ddram_addr !== 29'h2400000 || ddram_burstcnt !== 8'h80) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rd=%b addr=%0h cnt=%0h expected rd=1 addr=2400000 cnt=80",
                 k, ddram_rd, ddram_addr, ddram_burstcnt);
      end
      tick();
    end
    ddram_busy = 1'b0;
    n_vec++; if (ddram_rd !== 1'b1) begin n_err++; $display("FAIL bp_rd_before_accept: got %b expected 1", ddram_rd); end
    tick();
    n_vec++; if (ddram_rd !== 1'b0) begin n_err++; $display("FAIL bp_rd_after_accept: got %b expected 0", ddram_rd); end
    deliver(0, BL - 1, 0, -1, -1, -1);
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL bp_pass: got %b expected 1", pass); end
    tick();
    n_vec++; if (rd_rise - r0 !== 1) begin n_err++; $display("FAIL bp_req_cnt: got %0d expected 1", rd_rise - r0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_corruption();
    start_accept();
    deliver(0, BL - 1, 0, 5, 70, -1);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL cor_done: got %b expected 1", done); end
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL cor_err: got %0d expected 2", err_count); end
    n_vec++; if (first_err_idx !== 8'd5) begin n_err++; $display("FAIL cor_fidx: got %0d expected 5", first_err_idx); end
    n_vec++; if (first_err_data !== 32'h000000FF) begin n_err++; $display("FAIL cor_fdata: got %0h expected ff", first_err_data); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL cor_pass: got %b expected 0", pass); end
    tick();
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL cor_err_hold: got %0d expected 2", err_count); end
  endtask

  task automatic test_gapped_start();
    int d0, r0;
    d0 = done_cnt; r0 = rd_rise;
    start_accept();
    deliver(0, BL - 1, 3, -1, -1, 20);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL gap_done: got %b expected 1", done); end
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL gap_pass: got %b expected 1", pass); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL gap_err: got %0h expected 0", err_count); end
    repeat (5) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy_after: got %b expected 0", busy); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL gap_done_cnt: got %0d expected 1", done_cnt - d0); end
    n_vec++; if (rd_rise - r0 !== 1) begin n_err++; $display("FAIL gap_req_cnt: got %0d expected 1", rd_rise - r0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_accept();
    deliver(0, 39, 0, 3, -1, -1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0 || ddram_rd !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctrl: got busy=%b rd=%b done=%b expected 0 0 0", busy, ddram_rd, done); end
    n_vec++; if (err_count !== 8'h00 || first_err_idx !== 8'h00 || first_err_data !== 32'h0) begin
      n_err++; $display("FAIL rmid_results: got err=%0h fidx=%0h fdata=%0h expected 0 0 0",
                        err_count, first_err_idx, first_err_data); end
    n_vec++; if (pass !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL rmid_flags: got pass=%b timeout=%b expected 0 0", pass, timeout); end
    deliver(40, BL - 1, 0, 60, -1, -1);
    tick();
    n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d expected 0", done_cnt - d0); end
    n_vec++; if (busy !== 1'b0 || err_count !== 8'h00) begin
      n_err++; $display("FAIL rmid_idle: got busy=%b err=%0h expected 0 0", busy, err_count); end
    start_accept();
    deliver(0, BL - 1, 0, -1, -1, -1);
    n_vec++; if (done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL rmid_rerun: got done=%b pass=%b expected 1 1", done, pass); end
    tick();
  endtask

`ifdef DDR3_READ_WATCHDOG_EN
  task automatic test_watchdog();
    int k;
    start_accept();
    deliver(0, 49, 0, -1, -1, -1);
    k = 0;
    while (k < 100) begin
      tick();
      k++;
      if (done === 1'b1) break;
    end
    n_vec++; if (k !== 16) begin n_err++; $display("FAIL wd_latency: got %0d cycles expected 16", k); end
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL wd_timeout: got %b expected 1", timeout); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL wd_pass: got %b expected 0", pass); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL wd_err: got %0h expected 0", err_count); end
    tick();
    start_accept();
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b expected 0", timeout); end
    deliver(0, BL - 1, 0, -1, -1, -1);
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL wd_rerun_pass: got %b expected 1", pass); end
    tick();
  endtask
`else
  task automatic test_stall();
    int d0;
    d0 = done_cnt;
    start_accept();
    deliver(0, 49, 0, -1, -1, -1);
    repeat (200) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b expected 1", busy); end
    n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL stall_no_done: got %0d expected 0", done_cnt - d0); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got %b expected 0", timeout); end
    deliver(50, BL - 1, 0, -1, -1, -1);
    n_vec++; if (done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL stall_finish: got done=%b pass=%b expected 1 1", done, pass); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_backpressure();
    test_corruption();
    test_gapped_start();
    test_reset_mid();
`ifdef DDR3_READ_WATCHDOG_EN
    test_watchdog();
`else
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
